mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Sequencing controller that builds a WIDTH x WIDTH unsigned product by time-multiplexing one
//  2-bit x 2-bit multiplier cell over all radix-4 digit pairs, accumulating shifted partial products.
//  Sits between an operand producer and a result consumer, with valid/ready handshakes on both
//  sides. Trades area for latency: one shared 2x2 cell instead of a full array.
// PARAMETERS
//  WIDTH    8   operand width in bits; must be even and >= 4. DIGITS = WIDTH/2, CYCLES = DIGITS*DIGITS.
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         reset, synchronous, active-high
//  in_valid   in   1         operand pair valid
//  in_ready   out  1         controller accepts operands (high only in IDLE)
//  in_a       in   WIDTH     multiplicand, unsigned
//  in_b       in   WIDTH     multiplier, unsigned
//  out_valid  out  1         product valid (high only in DONE)
//  out_ready  in   1         consumer accepts product
//  out_p      out  2*WIDTH   product a*b, unsigned
//  busy       out  1         high in RUN or DONE
// BEHAVIOUR
//  - Reset (any state, including mid-operation): state=IDLE, accumulator=0, digit indices=0,
//    out_p=0, out_valid=0, busy=0; in_ready=1 from the first cycle after reset. Partial result discarded.
//  - FSM states: IDLE, RUN, DONE. in_ready/out_valid/busy decode from registered state only.
//  - IDLE: in_valid&in_ready -> latch in_a/in_b, clear acc, i=0, j=0, go RUN. Else stay.
//  - RUN: each cycle: pp = a_dig[i]*b_dig[j] from 2x2 cell (4 bits, max 9);
//    acc <= acc + (pp << 2*(i+j)), acc is 2*WIDTH bits, no overflow possible.
//    Index order: j increments 0..DIGITS-1; on j wrap, j=0 and i increments.
//    On the step with i=j=DIGITS-1: out_p <= acc + final term, go DONE.
//  - in_valid while RUN/DONE is ignored (in_ready=0); latched operands unaffected by input changes.
//  - DONE: out_valid=1, out_p held stable until out_valid&out_ready; then go IDLE, out_valid=0,
//    out_p keeps last value.
//  - Latency: operands accepted at edge T -> out_valid high in the cycle after edge T+CYCLES
//    (17 clocks for WIDTH=8). Min initiation interval CYCLES+2 (IDLE accept + RUN + DONE hand-off).
//  - out_ready while not DONE: ignored. No overlap of accept and deliver (in_ready=0 in DONE).
//  - Zero operands: no shortcut; full CYCLES sequence still run, result 0.
// STRUCTURE
//  - Shared package mul_seq_pkg: state enum {IDLE,RUN,DONE}, localparams DIGITS, CYCLES,
//    digit-index width function, width/evenness check helper.
//  - One sub-module mul2x2_cell: pure combinational 2x2 unsigned multiply (a[1:0], b[1:0] ->
//    p[3:0]), gate form p0=a0b0, p1=a1b0^a0b1, carry into p2/p3; no reset, no state.
//  - Top holds FSM, operand registers, digit muxes, shifter, accumulator, output register.
//  - Elaboration-time error if WIDTH odd or < 4.
// TESTING
//  1. Reset, in_a=3,in_b=3 pulsed valid -> out_valid exactly 17 cycles later, out_p=16'd9.
//  2. in_a=8'hFF,in_b=8'hFF -> out_p=16'hFE01; in_a=8'hA5,in_b=8'h3C -> out_p=16'h26AC.
//  3. in_a=0,in_b=8'h7F -> out_p=0 after full 17 cycles; busy high throughout RUN/DONE.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid/out_p stable; on out_ready=1
//     handshake -> IDLE next cycle, in_ready=1.
//  5. Assert reset at RUN cycle 8 -> next cycle IDLE, out_valid=0, out_p=0; new op 2*3 -> 6.
//  6. in_valid held high with changing operands during RUN -> ignored; result matches first
//     accepted pair; back-to-back ops spaced 18 cycles; random 1000-pair scoreboard vs a*b.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and elaboration helpers for the sequential radix-4 multiplier controller.
// The state enum and width helpers are used by the RTL and the bench.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DIGITS    = DEF_WIDTH / 2;
  localparam int CYCLES    = DIGITS * DIGITS;

  function automatic int digits_of(input int width);
    return width / 2;
  endfunction

  // Width of a radix-4 digit index; at least one bit even for tiny operands.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 4) && ((width % 2) == 0);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_mul2x2_cell.sv
// Combinational 2-bit x 2-bit unsigned multiplier in explicit gate form.
// Product is at most 9, so four output bits are enough.
module mul2x2_cell (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic a0b0;
  logic a1b0;
  logic a0b1;
  logic a1b1;
  logic c1;

  assign a0b0 = a[0] & b[0];
  assign a1b0 = a[1] & b[0];
  assign a0b1 = a[0] & b[1];
  assign a1b1 = a[1] & b[1];

  // Column 1 is a half adder; its carry merges with a1b1 in column 2.
  assign c1   = a1b0 & a0b1;
  assign p[0] = a0b0;
  assign p[1] = a1b0 ^ a0b1;
  assign p[2] = a1b1 ^ c1;
  assign p[3] = a1b1 & c1;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier: one shared 2x2 cell walks every
// radix-4 digit pair and accumulates shifted partial products.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; ready never depends on valid, and once out_valid rises out_p is held
// until the consumer takes it.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy,
  output state_t             dbg_state
);

  localparam int DIG = digits_of(WIDTH);
  localparam int IW  = idx_width(DIG);
  localparam int PW  = 2 * WIDTH;

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("mul_seq_ctrl: WIDTH must be even and at least 4");
  end

  state_t          state_q;
  state_t          state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    i_q;
  logic [IW-1:0]    j_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    p_q;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [1:0]       a_dig;
  logic [1:0]       b_dig;
  logic [3:0]       pp;
  logic [IW+1:0]    shamt;
  logic [PW-1:0]    pp_ext;
  logic [PW-1:0]    acc_sum;
  logic             last_step;
  logic             j_wrap;

  // Digit select: shift the operand down by two bits per digit index.
  assign a_sh  = a_q >> {i_q, 1'b0};
  assign b_sh  = b_q >> {j_q, 1'b0};
  assign a_dig = a_sh[1:0];
  assign b_dig = b_sh[1:0];

  mul2x2_cell u_cell (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  // Partial product weight is 4^(i+j), i.e. a left shift by 2*(i+j).
  assign shamt   = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
  assign pp_ext  = {{(PW-4){1'b0}}, pp} << shamt;
  assign acc_sum = acc_q + pp_ext;

  assign j_wrap    = (j_q == IW'(DIG - 1));
  assign last_step = (i_q == IW'(DIG - 1)) && j_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (last_step) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
      p_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_sum;
          if (last_step) begin
            p_q <= acc_sum;
          end else if (j_wrap) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_p     = p_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed scenarios plus a randomized
// scoreboard against a plain a*b reference.
module tb_mul_seq_ctrl;
  import mul_seq_pkg::*;

  localparam int W   = 8;
  localparam int LAT = CYCLES + 1;
  localparam int II  = CYCLES + 2;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;
  state_t         dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned x;
    longint unsigned y;
    x = a;
    y = b;
    return (2*W)'(x * y);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    exp_q.push_back(ref_mul(a, b));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge; lat counts that negedge as 1.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 1;
    busy_ok = (busy === 1'b1);
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic recv(output logic [2*W-1:0] p);
    p         = out_p;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_p !== '0) $display("FAIL reset_out_p: got %h want 0", out_p); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int lat;
    bit bok;
    logic [2*W-1:0] p;
    send(8'd3, 8'd3);
    wait_done(lat, bok);
    total_cnt++;
    if (lat != LAT) $display("FAIL latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    recv(p);
    total_cnt++;
    if (p !== exp_q[0]) $display("FAIL latency_result: got %h want %h", p, exp_q[0]); else pass_cnt++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_corners();
    logic [W-1:0] ta[2];
    logic [W-1:0] tb[2];
    int lat;
    bit bok;
    logic [2*W-1:0] p;
    logic [2*W-1:0] e;
    ta[0] = 8'hFF; tb[0] = 8'hFF;
    ta[1] = 8'hA5; tb[1] = 8'h3C;
    for (int k = 0; k < 2; k++) begin
      send(ta[k], tb[k]);
      wait_done(lat, bok);
      recv(p);
      e = exp_q.pop_front();
      total_cnt++;
      if (p !== e) $display("FAIL corner_%0d: got %h want %h", k, p, e); else pass_cnt++;
    end
  endtask

  task automatic test_zero_busy();
    int lat;
    bit bok;
    logic [2*W-1:0] p;
    logic [2*W-1:0] e;
    send(8'h00, 8'h7F);
    wait_done(lat, bok);
    total_cnt++;
    if (lat != LAT) $display("FAIL zero_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++;
    if (!bok) $display("FAIL zero_busy: busy dropped during RUN/DONE, want 1"); else pass_cnt++;
    recv(p);
    e = exp_q.pop_front();
    total_cnt++;
    if (p !== e) $display("FAIL zero_result: got %h want %h", p, e); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL zero_busy_idle: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat;
    bit bok;
    bit stable;
    logic [2*W-1:0] p;
    logic [2*W-1:0] e;
    send(W'($urandom_range(1, 255)), W'($urandom_range(1, 255)));
    wait_done(lat, bok);
    e      = exp_q.pop_front();
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_p !== e) stable = 1'b0;
    end
    total_cnt++;
    if (!stable) $display("FAIL bp_stable: out_valid=%b out_p=%h want 1/%h", out_valid, out_p, e);
    else pass_cnt++;
    recv(p);
    total_cnt++;
    if (p !== e) $display("FAIL bp_result: got %h want %h", p, e); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_p !== e) $display("FAIL bp_hold_last: got %h want %h", out_p, e); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit bok;
    logic [2*W-1:0] p;
    logic [2*W-1:0] e;
    send(8'hC3, 8'h5A);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_state: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    else pass_cnt++;
    total_cnt++;
    if (out_p !== '0) $display("FAIL midrst_out_p: got %h want 0", out_p); else pass_cnt++;
    send(8'd2, 8'd3);
    wait_done(lat, bok);
    recv(p);
    e = exp_q.pop_front();
    total_cnt++;
    if (p !== e) $display("FAIL midrst_result: got %h want %h", p, e); else pass_cnt++;
  endtask

  task automatic test_ignore_inputs();
    int lat;
    bit ign_ok;
    logic [2*W-1:0] p;
    logic [2*W-1:0] e;
    send(W'($urandom), W'($urandom));
    ign_ok = 1'b1;
    lat    = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) ign_ok = 1'b0;
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (!ign_ok) $display("FAIL ignore_ready: in_ready rose during RUN, want 0"); else pass_cnt++;
    total_cnt++;
    if (lat != LAT) $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    recv(p);
    e = exp_q.pop_front();
    total_cnt++;
    if (p !== e) $display("FAIL ignore_result: got %h want %h", p, e); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int accepted;
    int got;
    int last_acc;
    logic [2*W-1:0] e;
    cyc       = 0;
    accepted  = 0;
    got       = 0;
    last_acc  = 0;
    in_a      = W'($urandom);
    in_b      = W'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (got < 4 && cyc < 200) begin
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (out_p !== e) $display("FAIL b2b_result_%0d: got %h want %h", got, out_p, e); else pass_cnt++;
        got++;
      end
      if (in_ready === 1'b1 && accepted < 4) begin
        exp_q.push_back(ref_mul(in_a, in_b));
        if (accepted > 0) begin
          total_cnt++;
          if (cyc - last_acc != II)
            $display("FAIL b2b_spacing_%0d: got %0d want %0d", accepted, cyc - last_acc, II);
          else pass_cnt++;
        end
        last_acc = cyc;
        accepted++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      in_a = W'($urandom);
      in_b = W'($urandom);
      if (accepted >= 4) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (got != 4) $display("FAIL b2b_count: got %0d results want 4", got); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat;
    bit bok;
    int bad;
    logic [2*W-1:0] p;
    logic [2*W-1:0] e;
    for (int k = 0; k < 1000; k++) begin
      send(W'($urandom), W'($urandom));
      wait_done(lat, bok);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      recv(p);
      e   = exp_q.pop_front();
      bad = 0;
      if (lat != LAT) bad = 1;
      total_cnt++;
      if (p !== e || bad != 0)
        $display("FAIL random_%0d: got %h lat %0d want %h lat %0d", k, p, lat, e, LAT);
      else pass_cnt++;
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL random_queue: %0d left want 0", exp_q.size()); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_zero_busy();
    test_backpressure();
    test_reset_mid_run();
    test_ignore_inputs();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
